// File: rtl/wave_capture.sv
// wave_capture: captures one 256-sample frame of audio into the RAM half that
// the display is not reading, starting at a negative-to-nonnegative zero
// crossing (or after TIMEOUT samples with no crossing). Halves swap only during
// display blanking, so the visible frame never changes mid-scan.
//
// Ports:
//   clk, reset (async, active-low)
//   new_sample_ready / new_sample_in : one-cycle sample strobe and signed sample
//   wave_display_idle                : display is in blanking
//   freeze                           : blocks new triggers (capture stays armed)
//   write_address / write_enable / write_sample : sample RAM write port
//   read_index                       : RAM half currently displayed
module wave_capture #(
  parameter int SAMPLE_W = 16,
  parameter int TIMEOUT  = 2048
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  input  logic                freeze,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_prev_msb;
  logic [7:0]  r_wr_count;
  logic [15:0] r_timeout;
  logic        r_read_index;

  logic        w_msb;
  logic        w_trigger;
  logic        w_timeout_hit;
  logic        w_arm_fire;
  logic        w_write;
  logic        w_last_write;
  logic        w_swap;
  logic        w_armed_count;

  assign w_msb         = new_sample_in[SAMPLE_W-1];
  // Crossing from negative (previous MSB set) to nonnegative (current MSB clear).
  assign w_trigger     = new_sample_ready & r_prev_msb & ~w_msb;
  assign w_timeout_hit = new_sample_ready & (r_timeout == TIMEOUT_LAST);
  assign w_arm_fire    = (r_state == ST_ARMED) & ~freeze & (w_trigger | w_timeout_hit);
  assign w_armed_count = (r_state == ST_ARMED) & ~freeze & new_sample_ready;
  assign w_write       = (r_state == ST_ACTIVE) & new_sample_ready;
  assign w_last_write  = w_write & (r_wr_count == 8'hFF);
  // WAIT never evaluates triggers, so a sample arriving on the swap edge is
  // only seen by the prev_msb register.
  assign w_swap        = (r_state == ST_WAIT) & wave_display_idle;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARMED:  if (w_arm_fire)   w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_last_write) w_state_nxt = ST_WAIT;
      ST_WAIT:   if (w_swap)       w_state_nxt = ST_ARMED;
      default:                     w_state_nxt = ST_ARMED;
    endcase
  end

  // Output logic: the write strobe follows the sample strobe combinationally
  // so the RAM sees the sample in the same cycle it is presented.
  always_comb begin
    write_enable = 1'b0;
    if (r_state == ST_ACTIVE) begin
      write_enable = new_sample_ready;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_msb   <= 1'b0;
      r_wr_count   <= 8'd0;
      r_timeout    <= 16'd0;
      r_read_index <= 1'b0;
    end else begin
      if (new_sample_ready) begin
        r_prev_msb <= w_msb;
      end
      // 8-bit counter wraps to 0 on the 256th write, ready for the next frame.
      if (w_write) begin
        r_wr_count <= r_wr_count + 8'd1;
      end
      if (w_swap) begin
        r_read_index <= ~r_read_index;
      end
      if (w_swap || w_arm_fire) begin
        r_timeout <= 16'd0;
      end else if (w_armed_count) begin
        r_timeout <= r_timeout + 16'd1;
      end
    end
  end

  // Writes always go to the half that is not on screen.
  assign write_address = {~r_read_index, r_wr_count};
  // Top 8 bits with inverted sign: signed to offset-binary (+128 mod 256).
  assign write_sample  = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};
  assign read_index    = r_read_index;

  // Only the top byte of the sample is stored.
  generate
    if (SAMPLE_W > 8) begin : g_lsbs
      logic w_unused_lsbs;
      assign w_unused_lsbs = ^new_sample_in[SAMPLE_W-9:0];
    end
  endgenerate

endmodule

// File: tb/tb_wave_capture.sv
module tb_wave_capture;
  localparam int SW = 16;
  localparam int TO = 4;
  localparam int P_ARM  = 0;
  localparam int P_CAP  = 1;
  localparam int P_WAIT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          new_sample_ready;
  logic [SW-1:0] new_sample_in;
  logic          wave_display_idle;
  logic          freeze;
  logic [8:0]    write_address;
  logic          write_enable;
  logic [7:0]    write_sample;
  logic          read_index;

  always #5 clk = ~clk;

  wave_capture #(.SAMPLE_W(SW), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .freeze            (freeze),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which phase of the capture we are in, how many samples
  // of the frame are stored, samples seen while armed, displayed half.
  int m_phase, m_count, m_quiet, m_disp;
  bit m_prev_neg;

  logic       obs_we, obs_ri, exp_we, exp_ri;
  logic [8:0] obs_addr, exp_addr;
  logic [7:0] obs_dat, exp_dat;

  task automatic model_reset();
    m_phase = P_ARM; m_count = 0; m_quiet = 0; m_disp = 0; m_prev_neg = 0;
  endtask

  task automatic model_edge(input bit rdy, input int s, input bit idle, input bit frz);
    bit neg = (s < 0);
    case (m_phase)
      P_ARM: if (rdy && !frz) begin
        if ((m_prev_neg && !neg) || (m_quiet == TO - 1)) begin
          m_phase = P_CAP; m_quiet = 0;
        end else begin
          m_quiet++;
        end
      end
      P_CAP: if (rdy) begin
        m_count++;
        if (m_count == 256) begin m_count = 0; m_phase = P_WAIT; end
      end
      default: if (idle) begin
        m_disp = 1 - m_disp; m_phase = P_ARM; m_quiet = 0;
      end
    endcase
    if (rdy) m_prev_neg = neg;
  endtask

  // One clock: drive at negedge, observe mid-cycle, advance model at posedge.
  task automatic step(input bit rdy, input int s, input bit idle, input bit frz);
    new_sample_ready  = rdy;
    new_sample_in     = s[SW-1:0];
    wave_display_idle = idle;
    freeze            = frz;
    #2;
    obs_we = write_enable; obs_addr = write_address;
    obs_dat = write_sample; obs_ri = read_index;
    exp_we   = (m_phase == P_CAP) && rdy;
    exp_addr = 9'((m_disp != 0) ? m_count : 256 + m_count);
    exp_dat  = 8'(((s >>> (SW - 8)) + 128) & 255);
    exp_ri   = (m_disp != 0);
    @(posedge clk);
    model_edge(rdy, s, idle, frz);
    @(negedge clk);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    reset = 1'b0; new_sample_ready = 1'b1; new_sample_in = 16'hFFFB;
    wave_display_idle = 1'b0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", write_enable); end
    total++; if (read_index !== 1'b0) begin bad++; $display("FAIL rst_ri: got %b want 0", read_index); end
    total++; if (write_address !== 9'h100) begin bad++; $display("FAIL rst_addr: got %h want 100", write_address); end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_trigger_capture();
    int pre[3] = '{3, -5, 3};
    foreach (pre[k]) begin
      step(1, pre[k], 0, 0);
      total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL trig_pre%0d_we: got %b want 0", k, obs_we); end
    end
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(0, rnd_sample(), 0, 0);
        total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL cap_gap_we: got %b want 0", obs_we); end
      end
      step(1, rnd_sample(), 0, 0);
      total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL cap_we[%0d]: got %b want 1", i, obs_we); end
      total++; if (obs_addr !== 9'(256 + i)) begin bad++; $display("FAIL cap_addr[%0d]: got %h want %h", i, obs_addr, 9'(256 + i)); end
      total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL cap_dat[%0d]: got %h want %h", i, obs_dat, exp_dat); end
    end
    step(1, rnd_sample(), 0, 0);
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL wait_we: got %b want 0", obs_we); end
  endtask

  task automatic test_wait_swap();
    int vals[3] = '{-32768, 32767, 0};
    logic [7:0] want[3] = '{8'h00, 8'hFF, 8'h80};
    step(1, -7, 0, 0);
    total++; if (obs_ri !== 1'b0) begin bad++; $display("FAIL swap_pre_ri: got %b want 0", obs_ri); end
    step(1, 9, 1, 0);   // crossing on the swap edge must not trigger
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL swap_edge_we: got %b want 0", obs_we); end
    step(1, -1, 0, 0);
    total++; if (obs_ri !== 1'b1) begin bad++; $display("FAIL swap_ri: got %b want 1", obs_ri); end
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL swap_notrig_we: got %b want 0", obs_we); end
    step(1, 0, 0, 0);
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL swap_trig_we: got %b want 0", obs_we); end
    for (int i = 0; i < 256; i++) begin
      int s;
      s = (i < 3) ? vals[i] : rnd_sample();
      step(1, s, 0, 0);
      total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL cap2_we[%0d]: got %b want 1", i, obs_we); end
      total++; if (obs_addr !== 9'(i)) begin bad++; $display("FAIL cap2_addr[%0d]: got %h want %h", i, obs_addr, 9'(i)); end
      if (i < 3) begin
        total++; if (obs_dat !== want[i]) begin bad++; $display("FAIL conv[%0d]: got %h want %h", i, obs_dat, want[i]); end
      end else begin
        total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL cap2_dat[%0d]: got %h want %h", i, obs_dat, exp_dat); end
      end
    end
  endtask

  task automatic test_timeout();
    step(1, 100, 0, 0);
    step(0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 100, 0, 0);
      total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL to_we[%0d]: got %b want 0", k, obs_we); end
      total++; if (obs_ri !== 1'b0) begin bad++; $display("FAIL to_ri[%0d]: got %b want 0", k, obs_ri); end
    end
    for (int i = 0; i < 100; i++) begin
      step(1, (i == 0) ? 100 : rnd_sample(), 0, 0);
      total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL to_cap_we[%0d]: got %b want 1", i, obs_we); end
      total++; if (obs_addr !== 9'(256 + i)) begin bad++; $display("FAIL to_cap_addr[%0d]: got %h want %h", i, obs_addr, 9'(256 + i)); end
    end
  endtask

  task automatic test_reset_abort();
    new_sample_ready = 1'b1; new_sample_in = 16'd123;
    #1;
    total++; if (write_enable !== 1'b1) begin bad++; $display("FAIL abort_pre_we: got %b want 1", write_enable); end
    reset = 1'b0;
    #1;
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL abort_we: got %b want 0", write_enable); end
    total++; if (read_index !== 1'b0) begin bad++; $display("FAIL abort_ri: got %b want 0", read_index); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    begin
      int seq[4] = '{50, 50, -5, 3};
      foreach (seq[k]) begin
        step(1, seq[k], 0, 0);
        total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL rearm_we[%0d]: got %b want 0", k, obs_we); end
      end
    end
    step(1, 77, 0, 0);
    total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL rearm_first_we: got %b want 1", obs_we); end
    total++; if (obs_addr !== 9'h100) begin bad++; $display("FAIL rearm_first_addr: got %h want 100", obs_addr); end
  endtask

  task automatic test_freeze();
    int errs_we = 0, errs_ri = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step(1, 50, 0, 0);
    step(1, 50, 0, 0);
    for (int c = 0; c < 10000; c++) begin
      int s;
      s = (c % 2 == 0) ? -int'($urandom_range(1, 32768)) : int'($urandom_range(0, 32767));
      if (c == 9999) s = 77;
      step((c == 9999) ? 1'b1 : 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), 1);
      total++; if (obs_we !== 1'b0) begin bad++; errs_we++; if (errs_we < 5) $display("FAIL frz_we[%0d]: got %b want 0", c, obs_we); end
      total++; if (obs_ri !== 1'b0) begin bad++; errs_ri++; if (errs_ri < 5) $display("FAIL frz_ri[%0d]: got %b want 0", c, obs_ri); end
    end
    // Counter held at 2 through freeze: sample 2 after release fires timeout.
    step(1, 60, 0, 0);
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL unfrz_a_we: got %b want 0", obs_we); end
    step(1, 60, 0, 0);
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL unfrz_b_we: got %b want 0", obs_we); end
    step(1, 60, 0, 0);
    total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL unfrz_c_we: got %b want 1", obs_we); end
    total++; if (obs_addr !== 9'h100) begin bad++; $display("FAIL unfrz_c_addr: got %h want 100", obs_addr); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 8000; c++) begin
      int  s;
      bit  rdy, idle, frz;
      s    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 300)) - 150 : rnd_sample();
      rdy  = ($urandom_range(0, 2) != 0);
      idle = ($urandom_range(0, 7) == 0);
      frz  = ($urandom_range(0, 15) == 0);
      step(rdy, s, idle, frz);
      total++;
      if (obs_we !== exp_we || obs_ri !== exp_ri ||
          (exp_we && (obs_addr !== exp_addr || obs_dat !== exp_dat))) begin
        bad++; errs++;
        if (errs < 8)
          $display("FAIL rnd[%0d]: got we=%b ri=%b addr=%h dat=%h want we=%b ri=%b addr=%h dat=%h",
                   c, obs_we, obs_ri, obs_addr, obs_dat, exp_we, exp_ri, exp_addr, exp_dat);
      end
    end
  endtask

  initial begin
    reset = 1'b0; new_sample_ready = 1'b0; new_sample_in = '0;
    wave_display_idle = 1'b0; freeze = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_trigger_capture();
    test_wait_swap();
    test_timeout();
    test_reset_abort();
    test_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
